spell_mem_arbiter: RTL and testbench
====================================

SPELL_MEM_ARBITER -- requirements
Module: spell_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 Requester ports SHALL be, for n in {0,1}: reqn_valid in 1, request pending; reqn_addr in 8, byte address; reqn_wdata in 8, write data; reqn_type in 2, memory type (code/data encoding as memtypes); reqn_write in 1, 1=write 0=read; reqn_ready out 1, one-cycle completion pulse; reqn_rdata out 8, read data.
REQ-003 Memory-side ports SHALL be: mem_select out 1, transaction strobe; mem_addr out 8; mem_data_in out 8, write data to memory; mem_type out 2; mem_write out 1; mem_data_out in 8, read data from memory; mem_data_ready in 1, memory completion.
REQ-004 Status ports SHALL be: busy out 1, high in any state other than IDLE; grant out 1, index of the last-granted requester.

Function
REQ-005 The FSM SHALL have the states IDLE, ACCESS and RELEASE.
REQ-006 In IDLE, on an edge with at least one reqn_valid=1, the block SHALL select a winner, register its addr/wdata/type/write onto the mem_* outputs, set mem_select=1, set grant to the winner, and enter ACCESS.
REQ-007 Requester fields SHALL be captured only at grant; later changes, including reqn_valid dropping, SHALL NOT affect the transaction in flight.
REQ-008 In ACCESS, mem_select and all mem_* outputs SHALL hold stable until mem_data_ready=1 is sampled.
REQ-009 On the edge sampling mem_data_ready=1 in ACCESS, the block SHALL clear mem_select and pulse the winner's reqn_ready for exactly one cycle; on a read it SHALL also load reqn_rdata from mem_data_out. It SHALL then enter RELEASE.
REQ-010 RELEASE SHALL last exactly one cycle and then go to IDLE, so mem_select is low for at least 2 cycles between transactions.
REQ-011 Latency SHALL be as follows: with valid sampled at edge E0 and mem_data_ready first sampled high at Ek (k>=1), reqn_ready is high in cycle Ek..Ek+1, and the earliest next grant is at Ek+2.
REQ-012 reqn_rdata SHALL hold its value until that requester's next read completes; a write completion SHALL leave reqn_rdata unchanged.
REQ-013 A requester that still has valid high at Ek+2 SHALL be treated as issuing a new request.
REQ-014 mem_data_ready sampled in IDLE or RELEASE SHALL be ignored.
REQ-015 The ready output of the non-granted requester SHALL stay 0 at all times.
REQ-016 There SHALL be no timeout: ACCESS waits indefinitely for mem_data_ready.

Reset
REQ-017 Reset SHALL force the FSM to IDLE and drive mem_select=0, mem_addr=0, mem_data_in=0, mem_type=0, mem_write=0, req0_ready=req1_ready=0, req0_rdata=req1_rdata=0, busy=0 and grant=1.
REQ-018 Reset asserted during ACCESS SHALL drop mem_select at that same edge, SHALL NOT produce a ready pulse, and SHALL discard the transaction.
REQ-019 The first edge after reset deasserts SHALL be able to grant.

Configuration
REQ-020 When SPELL_ARB_ROUND_ROBIN_EN is defined, arbitration SHALL be round-robin: if both requesters are valid, the one not equal to grant wins; otherwise the sole valid requester wins. Because reset sets grant=1, req0 wins the first contention.
REQ-021 When SPELL_ARB_ROUND_ROBIN_EN is undefined, arbitration SHALL be fixed priority, with req0 always beating req1; grant still reports the winner.

Verification
REQ-022 The bench SHALL cover a single write. Stimulus: req0 writes addr=50, wdata=42, type=Data, with the memory model asserting data_ready 3 cycles after select. Response: mem_addr=50 and mem_data_in=42 with mem_write=1 held for 3 cycles, one req0_ready pulse, req0_rdata=0.
REQ-023 The bench SHALL cover a single read. Stimulus: req1 reads addr=50, type=Data, with the model returning 42. Response: req1_ready pulses once, req1_rdata=42, req0_rdata unchanged.
REQ-024 The bench SHALL cover contention. Stimulus: req0 and req1 both hold valid for 4 transactions. Response with the macro defined: grant order 0,1,0,1. Response without the macro: 0,0,0,0.
REQ-025 The bench SHALL cover a mid-access drop. Stimulus: req0 drops valid one cycle after grant. Response: the transaction completes, req0_ready still pulses, and no second request is issued.
REQ-026 The bench SHALL cover reset mid-access. Stimulus: reset asserted during ACCESS before data_ready. Response: next cycle mem_select=0, busy=0, no ready pulse, grant=1.
REQ-027 The bench SHALL cover the select gap. Stimulus: back-to-back requests from req1 with data_ready at 1 cycle. Response: mem_select low for exactly 2 cycles between strobes, and mem_select is never high while in RELEASE.

Source files
------------

// File: rtl/spell_mem_arbiter.sv
// Two-requester arbiter for a single handshake memory port: IDLE -> ACCESS -> RELEASE.
// Define SPELL_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (req0 first).
module spell_mem_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic [1:0] req0_type,
  input  logic       req0_write,
  output logic       req0_ready,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  input  logic [1:0] req1_type,
  input  logic       req1_write,
  output logic       req1_ready,
  output logic [7:0] req1_rdata,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic [1:0] mem_type,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,
  output logic       busy,
  output logic       grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t          state_q, state_d;
  logic            mem_select_q, mem_select_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [7:0]      mem_data_in_q, mem_data_in_d;
  logic [1:0]      mem_type_q, mem_type_d;
  logic            mem_write_q, mem_write_d;
  logic            grant_q, grant_d;
  logic [1:0]      ready_q, ready_d;
  logic [1:0][7:0] rdata_q, rdata_d;

  logic [1:0]      valid_vec;
  logic [1:0][7:0] addr_vec;
  logic [1:0][7:0] wdata_vec;
  logic [1:0][1:0] type_vec;
  logic [1:0]      write_vec;
  logic            win;

  assign valid_vec = {req1_valid, req0_valid};
  assign addr_vec  = {req1_addr, req0_addr};
  assign wdata_vec = {req1_wdata, req0_wdata};
  assign type_vec  = {req1_type, req0_type};
  assign write_vec = {req1_write, req0_write};

  // Winner index; only meaningful when at least one requester is valid.
  always_comb begin
`ifdef SPELL_ARB_ROUND_ROBIN_EN
    win = (&valid_vec) ? ~grant_q : ~valid_vec[0];
`else
    win = ~valid_vec[0];
`endif
  end

  always_comb begin
    state_d       = state_q;
    mem_select_d  = mem_select_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_type_d    = mem_type_q;
    mem_write_d   = mem_write_q;
    grant_d       = grant_q;
    ready_d       = 2'b00;
    rdata_d       = rdata_q;
    case (state_q)
      IDLE: begin
        if (|valid_vec) begin
          mem_select_d  = 1'b1;
          mem_addr_d    = addr_vec[win];
          mem_data_in_d = wdata_vec[win];
          mem_type_d    = type_vec[win];
          mem_write_d   = write_vec[win];
          grant_d       = win;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_data_ready) begin
          mem_select_d     = 1'b0;
          ready_d[grant_q] = 1'b1;
          if (!mem_write_q) begin
            rdata_d[grant_q] = mem_data_out;
          end
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_select_q  <= 1'b0;
      mem_addr_q    <= 8'd0;
      mem_data_in_q <= 8'd0;
      mem_type_q    <= 2'd0;
      mem_write_q   <= 1'b0;
      grant_q       <= 1'b1;
      ready_q       <= 2'b00;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      mem_select_q  <= mem_select_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_type_q    <= mem_type_d;
      mem_write_q   <= mem_write_d;
      grant_q       <= grant_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
    end
  end

  assign mem_select  = mem_select_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_type    = mem_type_q;
  assign mem_write   = mem_write_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign req0_ready  = ready_q[0];
  assign req1_ready  = ready_q[1];
  assign req0_rdata  = rdata_q[0];
  assign req1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench for spell_mem_arbiter with a latency-programmable memory model and a strobe monitor.
module tb_spell_mem_arbiter;

  localparam logic [1:0] TYPE_CODE = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic [1:0] req0_type = 0, req1_type = 0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_rdata, req1_rdata;
  logic       mem_select, mem_write, busy, grant;
  logic [7:0] mem_addr, mem_data_in;
  logic [1:0] mem_type;
  logic [7:0] mem_data_out = 0;
  logic       mem_data_ready = 0;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  int         lat = 1;
  int         sel_cnt = 0;
  logic [7:0] model_rdata = 0;

  // Monitor state
  int   rises, rdy0, rdy1, both_rdy, low_run, high_run, last_high, gap_min, gap_max;
  logic sel_prev, seen_high;
  int   glog[$];

  spell_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_type(req0_type), .req0_write(req0_write), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_type(req1_type), .req1_write(req1_write), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_type(mem_type), .mem_write(mem_write), .mem_data_out(mem_data_out),
    .mem_data_ready(mem_data_ready), .busy(busy), .grant(grant)
  );

  always #5 clock = ~clock;

  // Memory: raise data_ready so it is sampled on the lat-th edge after select rises.
  initial forever begin
    @(negedge clock);
    if (mem_select) sel_cnt = sel_cnt + 1;
    else sel_cnt = 0;
    mem_data_ready = mem_select && (sel_cnt == lat);
    mem_data_out   = model_rdata;
  end

  task automatic clear_mon();
    rises = 0; rdy0 = 0; rdy1 = 0; both_rdy = 0; low_run = 0; high_run = 0;
    last_high = 0; gap_min = 1000; gap_max = 0; sel_prev = mem_select; seen_high = 0;
    glog.delete();
  endtask

  initial begin
    clear_mon();
    forever begin
      @(posedge clock);
      #1;
      if (mem_select) begin
        if (!sel_prev) begin
          rises = rises + 1;
          glog.push_back(int'(grant));
          if (seen_high) begin
            if (low_run < gap_min) gap_min = low_run;
            if (low_run > gap_max) gap_max = low_run;
          end
          $display("txn %0d: grant=%0d addr=%0d wdata=%0d write=%0d", rises, grant, mem_addr, mem_data_in, mem_write);
        end
        seen_high = 1;
        high_run = high_run + 1;
        low_run = 0;
      end else begin
        if (sel_prev) last_high = high_run;
        high_run = 0;
        low_run = low_run + 1;
      end
      if (req0_ready) rdy0 = rdy0 + 1;
      if (req1_ready) rdy1 = rdy1 + 1;
      if (req0_ready && req1_ready) both_rdy = both_rdy + 1;
      sel_prev = mem_select;
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy) begin done = 1; break; end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL wait_idle: busy=%0d required 0 within 60 cycles", busy); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    checks++; if (mem_select !== 1'b0) begin errors++; $display("FAIL rst_select got %0d want 0", mem_select); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy); end
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rst_grant got %0d want 1", grant); end
    checks++; if ({mem_addr, mem_data_in, mem_type, mem_write} !== 19'd0) begin
      errors++; $display("FAIL rst_mem_fields got addr=%0d data=%0d type=%0d write=%0d want 0", mem_addr, mem_data_in, mem_type, mem_write); end
    checks++; if ({req0_ready, req1_ready, req0_rdata, req1_rdata} !== 18'd0) begin
      errors++; $display("FAIL rst_req_outputs got r0=%0d r1=%0d d0=%0d d1=%0d want 0", req0_ready, req1_ready, req0_rdata, req1_rdata); end
  endtask

  task automatic test_single_write();
    clear_mon();
    lat = 3;
    reset = 0;
    req0_valid = 1; req0_addr = 8'd50; req0_wdata = 8'd42; req0_type = TYPE_DATA; req0_write = 1;
    @(negedge clock);
    req0_valid = 0;
    checks++; if (mem_select !== 1'b1) begin errors++; $display("FAIL wr_first_edge_grant select=%0d want 1", mem_select); end
    checks++; if ({mem_addr, mem_data_in, mem_type, mem_write} !== {8'd50, 8'd42, TYPE_DATA, 1'b1}) begin
      errors++; $display("FAIL wr_fields got addr=%0d data=%0d type=%0d write=%0d want 50 42 1 1", mem_addr, mem_data_in, mem_type, mem_write); end
    checks++; if (grant !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_grant_busy got %0d %0d want 0 1", grant, busy); end
    wait_idle();
    repeat (2) @(negedge clock);
    checks++; if (last_high !== 3) begin errors++; $display("FAIL wr_select_len got %0d want 3", last_high); end
    checks++; if (rdy0 !== 1 || rdy1 !== 0) begin errors++; $display("FAIL wr_ready_pulses got r0=%0d r1=%0d want 1 0", rdy0, rdy1); end
    checks++; if (req0_rdata !== 8'd0) begin errors++; $display("FAIL wr_rdata got %0d want 0", req0_rdata); end
  endtask

  task automatic test_single_read();
    clear_mon();
    lat = 2; model_rdata = 8'd42;
    req1_valid = 1; req1_addr = 8'd50; req1_type = TYPE_DATA; req1_write = 0;
    @(negedge clock);
    req1_valid = 0;
    checks++; if (mem_select !== 1'b1 || mem_write !== 1'b0 || grant !== 1'b1) begin
      errors++; $display("FAIL rd_start got select=%0d write=%0d grant=%0d want 1 0 1", mem_select, mem_write, grant); end
    wait_idle();
    checks++; if (req1_rdata !== 8'd42) begin errors++; $display("FAIL rd_rdata got %0d want 42", req1_rdata); end
    checks++; if (req0_rdata !== 8'd0) begin errors++; $display("FAIL rd_other_rdata got %0d want 0", req0_rdata); end
    checks++; if (rdy1 !== 1 || rdy0 !== 0) begin errors++; $display("FAIL rd_ready_pulses got r0=%0d r1=%0d want 0 1", rdy0, rdy1); end
  endtask

  task automatic test_contention();
    int exp_g[4];
`ifdef SPELL_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    clear_mon();
    lat = 1; model_rdata = 8'h77;
    req0_valid = 1; req0_addr = 8'd10; req0_wdata = 8'd1; req0_type = TYPE_CODE; req0_write = 1;
    req1_valid = 1; req1_addr = 8'd20; req1_wdata = 8'd2; req1_type = TYPE_DATA; req1_write = 1;
    for (int i = 0; i < 60 && rises < 4; i++) @(negedge clock);
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    checks++; if (glog.size() !== 4) begin errors++; $display("FAIL cont_grant_count got %0d want 4", glog.size()); end
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      checks++; if (glog[i] !== exp_g[i]) begin errors++; $display("FAIL cont_grant_%0d got %0d want %0d", i, glog[i], exp_g[i]); end
    end
    checks++; if (both_rdy !== 0) begin errors++; $display("FAIL cont_dual_ready got %0d want 0", both_rdy); end
    checks++; if (req0_rdata !== 8'd0 || req1_rdata !== 8'd42) begin
      errors++; $display("FAIL cont_rdata_hold got %0d %0d want 0 42", req0_rdata, req1_rdata); end
  endtask

  task automatic test_mid_drop();
    clear_mon();
    lat = 3;
    req0_valid = 1; req0_addr = 8'd5; req0_wdata = 8'd9; req0_type = TYPE_DATA; req0_write = 1;
    @(negedge clock);
    req0_addr = 8'd99;
    @(negedge clock);
    req0_valid = 0;
    checks++; if (mem_addr !== 8'd5) begin errors++; $display("FAIL drop_addr_hold got %0d want 5", mem_addr); end
    wait_idle();
    repeat (4) @(negedge clock);
    checks++; if (rises !== 1) begin errors++; $display("FAIL drop_strobes got %0d want 1", rises); end
    checks++; if (rdy0 !== 1 || rdy1 !== 0) begin errors++; $display("FAIL drop_ready got r0=%0d r1=%0d want 1 0", rdy0, rdy1); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    lat = 1000;
    req0_valid = 1; req0_addr = 8'd33; req0_wdata = 8'd44; req0_write = 1;
    @(negedge clock);
    req0_valid = 0;
    checks++; if (busy !== 1'b1 || grant !== 1'b0) begin errors++; $display("FAIL rstmid_start got busy=%0d grant=%0d want 1 0", busy, grant); end
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    checks++; if (mem_select !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop got select=%0d busy=%0d want 0 0", mem_select, busy); end
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rstmid_grant got %0d want 1", grant); end
    reset = 0;
    repeat (4) @(negedge clock);
    checks++; if (rdy0 !== 0 || rdy1 !== 0 || rises !== 1) begin
      errors++; $display("FAIL rstmid_no_ready got r0=%0d r1=%0d strobes=%0d want 0 0 1", rdy0, rdy1, rises); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    lat = 1; model_rdata = 8'hA5;
    req1_valid = 1; req1_addr = 8'd60; req1_type = TYPE_DATA; req1_write = 0;
    for (int i = 0; i < 60 && rises < 3; i++) @(negedge clock);
    req1_valid = 0;
    wait_idle();
    checks++; if (rises !== 3) begin errors++; $display("FAIL b2b_strobes got %0d want 3", rises); end
    checks++; if (gap_min !== 2 || gap_max !== 2) begin errors++; $display("FAIL b2b_gap got min=%0d max=%0d want 2 2", gap_min, gap_max); end
    checks++; if (rdy1 !== 3 || rdy0 !== 0) begin errors++; $display("FAIL b2b_ready got r0=%0d r1=%0d want 0 3", rdy0, rdy1); end
    checks++; if (req1_rdata !== 8'hA5 || req0_rdata !== 8'd0) begin
      errors++; $display("FAIL b2b_rdata got %0d %0d want 165 0", req1_rdata, req0_rdata); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_mid_drop();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
